xeng_corr_out: RTL
==================

Name: xeng_corr_out

Overview:
- Output stage for the next-generation X-engine.
- Takes raw offset-binary tap accumulations for N_PROD polarisation products and pops one per-baseline correction set from an internal FIFO for each accumulation beat.
- Subtracts the scaled correction and emits signed results framed per window, with the MCNT of the window and error flags.
- Sits between the last baseline tap and the vector-accumulator/packetiser, replacing the unregistered fixed-4-stokes subtractor path.

Parameters:
- ACC_BITS, 20: width of each real/imag accumulation component (unsigned in, signed out).
- CORR_BITS, 15: width of each real/imag correction component (unsigned).
- CORR_SHIFT, 3: left shift applied to corrections before subtraction (BITWIDTH-1).
- N_PROD, 4: number of products per beat (1, 2 or 4).
- N_TAPS, 17: accumulation beats per window (N_ANTS/2+1).
- FIFO_DEPTH_BITS, 6: log2 correction FIFO depth; must satisfy 2^FIFO_DEPTH_BITS >= 2*N_TAPS.
- MCNT_WIDTH, 48: MCNT bus width.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: synchronous active-low reset.
- ce, input, 1: clock enable; ignored, kept for Simulink compatibility.
- sync_in, input, 1: sync pulse; samples mcnt_in.
- mcnt_in, input, MCNT_WIDTH: timestamp.
- acc_in, input, 2*N_PROD*ACC_BITS: accumulations, {re,im} per product, product 0 in the MSBs.
- acc_vld, input, 1: acc_in valid, one beat per tap.
- corr_in, input, 2*N_PROD*CORR_BITS: correction set, same ordering as acc_in.
- corr_vld, input, 1: push corr_in into the FIFO.
- dout, output, 2*N_PROD*ACC_BITS: corrected signed results.
- vld_out, output, 1: dout valid.
- win_start, output, 1: first beat of a window.
- sync_out, output, 1: first output beat of the first window started after sync_in.
- mcnt_out, output, MCNT_WIDTH: MCNT of the window being output.
- err_ovf, output, 1: sticky; FIFO overflow.
- err_unf, output, 1: sticky; FIFO underflow.
- err_sat, output, 1: sticky; result out of range.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FIFO is emptied and the state machine goes to IDLE.
  - All outputs go to 0, including sticky flags, mcnt_out and dout.
  - Reset mid-window discards the partial window; no further vld_out until a fresh window.
- Correction FIFO:
  - corr_vld pushes one entry.
  - Push while full: entry dropped, err_ovf set.
  - Each acc_vld beat pops one entry.
  - Pop while empty: zero correction is used, err_unf set.
  - Push and pop in the same cycle are both honoured; at full this is not an overflow, at empty the pushed entry is not bypassed (counts as underflow).
- State machine:
  - IDLE: acc_vld goes to RUN with tap_cnt=1 and flags that beat as window start; if N_TAPS==1, stay in IDLE.
  - RUN: each acc_vld beat increments tap_cnt; the beat with tap_cnt==N_TAPS-1 returns to IDLE with tap_cnt=0.
  - Gaps in acc_vld are allowed and do not advance the count.
- MCNT tracking:
  - sync_in captures mcnt_in into mcnt_pend and sets the armed flag.
  - On a window-start beat, mcnt_pend is transferred to the window MCNT; if armed, the window is tagged for sync_out and armed is cleared.
  - sync_in coincident with a window-start beat: the new mcnt_in is used and that window is tagged.
- Arithmetic, per component:
  - result = zero-extend(acc) − (zero-extend(corr) << CORR_SHIFT), computed at width max(ACC_BITS, CORR_BITS+CORR_SHIFT)+2.
  - Result is reduced to ACC_BITS signed as set by the optional feature below.
- Pipeline:
  - Latency is fixed at 2 cycles from acc_vld to vld_out. Stage 1 registers acc and the popped correction; stage 2 registers the result.
  - vld_out, win_start and sync_out are delayed in lockstep with dout.
  - mcnt_out updates on the win_start output beat and holds between windows.
- dout holds its last value when vld_out=0.

Optional Feature:
- XENG_CORR_SAT_EN defined:
  - Results above 2^(ACC_BITS-1)-1 or below −2^(ACC_BITS-1) clamp to those limits.
  - err_sat is set on any clamped component.
- Not defined:
  - Results wrap (low ACC_BITS bits kept).
  - err_sat is still set on out-of-range detection; saturation logic is omitted.

Test Plan:
1. Reset, push 17 corrections of all-3, send 17 acc beats of all-100 with CORR_SHIFT=3 -> 17 vld_out beats 2 cycles later, every component 76, win_start on beat 0 only, err flags 0.
2. sync_in with mcnt_in=0x1234, then a window -> mcnt_out=0x1234 and sync_out on the first output beat; the next window has sync_out=0.
3. acc beats with no corrections pushed -> dout equals acc, err_unf=1 and stays set; rst_n low clears it.
4. Push 2^FIFO_DEPTH_BITS+1 corrections with no pops -> err_ovf=1; the first 64 entries are popped intact in order.
5. acc=0, corr=1 with ACC_BITS=20 -> −8 (0xFFFF8); acc=0xFFFFF, corr=0 -> with XENG_CORR_SAT_EN, 0x7FFFF and err_sat=1; without it, 0xFFFFF and err_sat=1.
6. rst_n low after beat 8 of a window, then a full window -> no output from the partial window; the new window outputs 17 beats with win_start on its first beat.

Source files
------------

// File: rtl/xeng_corr_out.sv
// xeng_corr_out: X-engine output stage subtracting FIFO-fed corrections with window/MCNT framing.
// Define XENG_CORR_SAT_EN to clamp out-of-range results instead of wrapping them.
module xeng_corr_out #(
    parameter int ACC_BITS        = 20,
    parameter int CORR_BITS       = 15,
    parameter int CORR_SHIFT      = 3,
    parameter int N_PROD          = 4,
    parameter int N_TAPS          = 17,
    parameter int FIFO_DEPTH_BITS = 6,
    parameter int MCNT_WIDTH      = 48
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           ce,
    input  logic                           sync_in,
    input  logic [MCNT_WIDTH-1:0]          mcnt_in,
    input  logic [2*N_PROD*ACC_BITS-1:0]   acc_in,
    input  logic                           acc_vld,
    input  logic [2*N_PROD*CORR_BITS-1:0]  corr_in,
    input  logic                           corr_vld,
    output logic [2*N_PROD*ACC_BITS-1:0]   dout,
    output logic                           vld_out,
    output logic                           win_start,
    output logic                           sync_out,
    output logic [MCNT_WIDTH-1:0]          mcnt_out,
    output logic                           err_ovf,
    output logic                           err_unf,
    output logic                           err_sat
);
    localparam int NC    = 2 * N_PROD;
    localparam int AW    = NC * ACC_BITS;
    localparam int CW    = NC * CORR_BITS;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int CNTW  = FIFO_DEPTH_BITS + 1;
    localparam int W     = (ACC_BITS > CORR_BITS + CORR_SHIFT ? ACC_BITS : CORR_BITS + CORR_SHIFT) + 2;
    localparam int TW    = $clog2(N_TAPS + 1);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [CW-1:0]              r_mem [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] r_wp, r_rp;
    logic [CNTW-1:0]            r_cnt;
    logic [0:0]                 r_state;
    logic [TW-1:0]              r_tap;
    logic [MCNT_WIDTH-1:0]      r_mcnt_pend, r_s1_mcnt, r_mcnt_out;
    logic                       r_armed, r_s1_vld, r_s1_start, r_s1_sync;
    logic [AW-1:0]              r_s1_acc, r_dout;
    logic [CW-1:0]              r_s1_corr;
    logic                       r_vld, r_ws, r_sync, r_ovf, r_unf, r_sat;
    logic                       w_empty, w_full, w_pop, w_push, w_start, w_last, w_unused;
    logic [NC-1:0][W-1:0]       w_diff;
    logic [NC-1:0]              w_oor;
    logic [AW-1:0]              w_res;

    assign w_unused = ce;
    assign w_empty  = r_cnt == '0;
    assign w_full   = r_cnt[FIFO_DEPTH_BITS];
    assign w_pop    = acc_vld && !w_empty;
    // a pop in the same cycle frees the slot, so a push at full is still accepted
    assign w_push   = corr_vld && (!w_full || w_pop);
    assign w_start  = acc_vld && r_state == S_IDLE;
    assign w_last   = r_tap == TW'(N_TAPS - 1);

    for (genvar g = 0; g < NC; g++) begin : g_comp
        assign w_diff[g] = W'(r_s1_acc[g*ACC_BITS +: ACC_BITS])
                         - (W'(r_s1_corr[g*CORR_BITS +: CORR_BITS]) << CORR_SHIFT);
        assign w_oor[g]  = !(&w_diff[g][W-1:ACC_BITS-1] || ~|w_diff[g][W-1:ACC_BITS-1]);
`ifdef XENG_CORR_SAT_EN
        assign w_res[g*ACC_BITS +: ACC_BITS] = w_oor[g]
            ? {w_diff[g][W-1], {(ACC_BITS-1){!w_diff[g][W-1]}}} : w_diff[g][ACC_BITS-1:0];
`else
        assign w_res[g*ACC_BITS +: ACC_BITS] = w_diff[g][ACC_BITS-1:0];
`endif
    end

    always_ff @(posedge clk)
        if (w_push) r_mem[r_wp] <= corr_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
            r_tap       <= '0;
            r_mcnt_pend <= '0;
            r_armed     <= 1'b0;
            r_s1_vld    <= 1'b0;
            r_s1_start  <= 1'b0;
            r_s1_sync   <= 1'b0;
            r_s1_acc    <= '0;
            r_s1_corr   <= '0;
            r_s1_mcnt   <= '0;
            r_vld       <= 1'b0;
            r_ws        <= 1'b0;
            r_sync      <= 1'b0;
            r_dout      <= '0;
            r_mcnt_out  <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_wp   <= r_wp + FIFO_DEPTH_BITS'(w_push);
            r_rp   <= r_rp + FIFO_DEPTH_BITS'(w_pop);
            r_cnt  <= r_cnt + CNTW'(w_push) - CNTW'(w_pop);
            r_ovf  <= r_ovf | (corr_vld && !w_push);
            r_unf  <= r_unf | (acc_vld && w_empty);
            if (acc_vld) begin
                r_state   <= w_last ? S_IDLE : S_RUN;
                r_tap     <= w_last ? '0 : r_tap + TW'(1);
                r_s1_acc  <= acc_in;
                r_s1_corr <= w_empty ? '0 : r_mem[r_rp];
            end
            if (sync_in) r_mcnt_pend <= mcnt_in;
            r_armed    <= w_start ? 1'b0 : r_armed | sync_in;
            r_s1_vld   <= acc_vld;
            r_s1_start <= w_start;
            r_s1_sync  <= w_start && (sync_in || r_armed);
            if (w_start) r_s1_mcnt <= sync_in ? mcnt_in : r_mcnt_pend;
            r_vld  <= r_s1_vld;
            r_ws   <= r_s1_start;
            r_sync <= r_s1_sync;
            r_sat  <= r_sat | (r_s1_vld && |w_oor);
            if (r_s1_vld) r_dout <= w_res;
            if (r_s1_start) r_mcnt_out <= r_s1_mcnt;
        end
    end

    assign dout      = r_dout;
    assign vld_out   = r_vld;
    assign win_start = r_ws;
    assign sync_out  = r_sync;
    assign mcnt_out  = r_mcnt_out;
    assign err_ovf   = r_ovf;
    assign err_unf   = r_unf;
    assign err_sat   = r_sat;
endmodule
